// File: rtl/lfsr3_chk_pkg.sv
// Shared definitions for the 3-bit LFSR stage and its stream checker:
// checker states, fixed-point constants and the generator recurrence.
package lfsr3_chk_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } chk_state_e;

    localparam logic [2:0] LFSR3_FIXPT0 = 3'b000;
    localparam logic [2:0] LFSR3_FIXPT1 = 3'b001;

    function automatic logic [2:0] lfsr3_next(input logic [2:0] s);
        return {s[1], s[2], s[0] ^ s[2]};
    endfunction

endpackage

// File: rtl/lfsr3_stream_checker.sv
// Stream checker for the 3-bit LFSR stage: lock acquisition, saturating error
// count and stuck detection. Optional mismatch history under LFSR3_CHK_HIST_EN.
module lfsr3_stream_checker
    import lfsr3_chk_pkg::*;
#(
    parameter int unsigned LOCK_THRESH = 4,
    parameter int unsigned MISS_LIMIT  = 2,
    parameter int unsigned STUCK_LIMIT = 8,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       din,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             stuck,
    output logic [2:0]       err_got,
    output logic [2:0]       err_exp
);

    localparam logic [3:0] LOCK_N  = 4'(LOCK_THRESH);
    localparam logic [3:0] MISS_N  = 4'(MISS_LIMIT);
    localparam logic [7:0] STUCK_N = 8'(STUCK_LIMIT);

    chk_state_e       state_q, state_d;
    logic [2:0]       prev_q;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic [7:0]       stuck_cnt_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             err_pulse_q;
    logic [2:0]       exp_val;
    logic             match;
    logic             err_hit;
    logic             fixpt_hit;

    assign exp_val = lfsr3_next(prev_q);
    assign match   = (din == exp_val);

    // State register (lock counters travel with the state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    state_d     = SYNC;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
                SYNC: begin
                    if (match) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_q + 4'd1 == LOCK_N) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 4'd1;
                        if (miss_cnt_q + 4'd1 == MISS_N) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output/event decode
    always_comb begin
        err_hit   = 1'b0;
        fixpt_hit = 1'b0;
        if (din_valid) begin
            err_hit   = (state_q != HUNT) && !match;
            fixpt_hit = (din == LFSR3_FIXPT0) || (din == LFSR3_FIXPT1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            stuck_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= err_hit;
            if (din_valid) begin
                prev_q <= din;
            end
            // err_clr wins over a same-cycle mismatch or fixed-point sample
            if (err_clr) begin
                err_cnt_q   <= '0;
                stuck_cnt_q <= '0;
            end else begin
                if (err_hit && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
                if (din_valid) begin
                    if (!fixpt_hit) begin
                        stuck_cnt_q <= '0;
                    end else if (stuck_cnt_q != STUCK_N) begin
                        stuck_cnt_q <= stuck_cnt_q + 8'd1;
                    end
                end
            end
        end
    end

`ifdef LFSR3_CHK_HIST_EN
    logic [2:0] got_q, exp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got_q <= '0;
            exp_q <= '0;
        end else if (err_clr) begin
            got_q <= '0;
            exp_q <= '0;
        end else if (err_hit) begin
            got_q <= din;
            exp_q <= exp_val;
        end
    end

    assign err_got = got_q;
    assign err_exp = exp_q;
`else
    assign err_got = '0;
    assign err_exp = '0;
`endif

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign stuck     = (stuck_cnt_q == STUCK_N);

endmodule

// File: tb/tb_lfsr3_stream_checker.sv
// Directed table-driven bench for lfsr3_stream_checker (ERR_W=4 so saturation
// is reachable); history expectations follow LFSR3_CHK_HIST_EN.
module tb_lfsr3_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] din;
    logic       din_valid;
    logic       err_clr;
    logic       locked;
    logic       err_pulse;
    logic [3:0] err_cnt;
    logic       stuck;
    logic [2:0] err_got;
    logic [2:0] err_exp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lfsr3_stream_checker #(
        .LOCK_THRESH(4),
        .MISS_LIMIT (2),
        .STUCK_LIMIT(8),
        .ERR_W      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_valid(din_valid),
        .err_clr  (err_clr),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .stuck    (stuck),
        .err_got  (err_got),
        .err_exp  (err_exp)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [2:0] d;
        logic       clr;
        logic       l;
        logic       p;
        logic [3:0] c;
        logic       s;
        logic [2:0] g;
        logic [2:0] e;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic rst, logic v, logic [2:0] d, logic clr,
                                logic l, logic p, logic [3:0] c, logic s,
                                logic [2:0] g, logic [2:0] e);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.clr = clr;
        t.l = l; t.p = p; t.c = c; t.s = s; t.g = g; t.e = e;
        return t;
    endfunction

    function automatic logic [2:0] hist(logic [2:0] x);
`ifdef LFSR3_CHK_HIST_EN
        return x;
`else
        return 3'b000;
`endif
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic drive(logic rst, logic v, logic [2:0] d, logic clr);
        @(negedge clk);
        rst_n     = !rst;
        din_valid = v;
        din       = d;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string nm, logic l, logic p, logic [3:0] c, logic s,
                           logic [2:0] g, logic [2:0] e);
        chk({nm, ".locked"}, 16'(locked), 16'(l));
        chk({nm, ".err_pulse"}, 16'(err_pulse), 16'(p));
        chk({nm, ".err_cnt"}, 16'(err_cnt), 16'(c));
        chk({nm, ".stuck"}, 16'(stuck), 16'(s));
        chk({nm, ".err_got"}, 16'(err_got), 16'(hist(g)));
        chk({nm, ".err_exp"}, 16'(err_exp), 16'(hist(e)));
    endtask

    initial begin
        // Orbit-4 lock, single miss in LOCKED, double miss drops lock, relock
        tbl[0]  = mk(0, 1, 3'b100, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        tbl[1]  = mk(0, 1, 3'b011, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        tbl[2]  = mk(0, 1, 3'b101, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        tbl[3]  = mk(0, 1, 3'b010, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        tbl[4]  = mk(0, 1, 3'b100, 0, 1, 0, 0, 0, 3'b000, 3'b000);
        tbl[5]  = mk(0, 0, 3'b111, 0, 1, 0, 0, 0, 3'b000, 3'b000);
        tbl[6]  = mk(0, 1, 3'b011, 0, 1, 0, 0, 0, 3'b000, 3'b000);
        tbl[7]  = mk(0, 1, 3'b000, 0, 1, 1, 1, 0, 3'b000, 3'b101);
        tbl[8]  = mk(0, 1, 3'b000, 0, 1, 0, 1, 0, 3'b000, 3'b101);
        tbl[9]  = mk(0, 1, 3'b111, 0, 1, 1, 2, 0, 3'b111, 3'b000);
        tbl[10] = mk(0, 1, 3'b111, 0, 0, 1, 3, 0, 3'b111, 3'b110);
        tbl[11] = mk(0, 1, 3'b100, 0, 0, 0, 3, 0, 3'b111, 3'b110);
        tbl[12] = mk(0, 1, 3'b011, 0, 0, 0, 3, 0, 3'b111, 3'b110);
        tbl[13] = mk(0, 1, 3'b101, 0, 0, 0, 3, 0, 3'b111, 3'b110);
        tbl[14] = mk(0, 1, 3'b010, 0, 0, 0, 3, 0, 3'b111, 3'b110);
        tbl[15] = mk(0, 1, 3'b100, 0, 1, 0, 3, 0, 3'b111, 3'b110);
        // Reset, then orbit-2 lock
        tbl[16] = mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        tbl[17] = mk(0, 1, 3'b110, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        tbl[18] = mk(0, 1, 3'b111, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        tbl[19] = mk(0, 1, 3'b110, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        tbl[20] = mk(0, 1, 3'b111, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        tbl[21] = mk(0, 1, 3'b110, 0, 1, 0, 0, 0, 3'b000, 3'b000);

        rst_n     = 1'b0;
        din       = 3'b000;
        din_valid = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 3'b000, 3'b000);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].clr);
            chk_all($sformatf("vec%0d", i), tbl[i].l, tbl[i].p, tbl[i].c,
                    tbl[i].s, tbl[i].g, tbl[i].e);
        end

        // Stuck on fixed point 001
        drive(1, 0, 3'b000, 0);
        for (int k = 1; k <= 8; k++) begin
            drive(0, 1, 3'b001, 0);
            if (k == 7) chk("stuck.k7", 16'(stuck), 16'd0);
            if (k == 8) chk("stuck.k8", 16'(stuck), 16'd1);
        end
        chk("stuck.locked", 16'(locked), 16'd1);
        drive(0, 1, 3'b100, 0);
        chk("stuck.release", 16'(stuck), 16'd0);
        chk("stuck.err1", 16'(err_cnt), 16'd1);
        for (int k = 1; k <= 8; k++) drive(0, 1, 3'b001, 0);
        chk("stuck.again", 16'(stuck), 16'd1);
        chk("stuck.err2", 16'(err_cnt), 16'd2);
        drive(0, 0, 3'b000, 1);
        chk("clr.stuck", 16'(stuck), 16'd0);
        chk("clr.err_cnt", 16'(err_cnt), 16'd0);
        chk("clr.locked", 16'(locked), 16'd1);

        // Saturation with 20 mismatches in SYNC
        drive(1, 0, 3'b000, 0);
        drive(0, 1, 3'b100, 0);
        for (int k = 1; k <= 20; k++) begin
            drive(0, 1, 3'b100, 0);
            if (k == 14) chk("sat.k14", 16'(err_cnt), 16'd14);
        end
        chk("sat.err_cnt", 16'(err_cnt), 16'd15);
        chk("sat.pulse", 16'(err_pulse), 16'd1);
        chk("sat.got", 16'(err_got), 16'(hist(3'b100)));
        chk("sat.exp", 16'(err_exp), 16'(hist(3'b011)));
        drive(0, 1, 3'b100, 1);
        chk("clrmis.err_cnt", 16'(err_cnt), 16'd0);
        chk("clrmis.pulse", 16'(err_pulse), 16'd1);
        drive(0, 1, 3'b100, 0);
        chk("presrst.err_cnt", 16'(err_cnt), 16'd1);

        // Asynchronous reset mid-cycle while in SYNC
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("asyncrst", 0, 0, 0, 0, 3'b000, 3'b000);
        drive(0, 0, 3'b000, 0);
        chk_all("postrst", 0, 0, 0, 0, 3'b000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
